// File: rtl/weight_update_pkg.sv
// Shared state encoding, chunk-address sizing and fixed-point limits for the weight updater.
package weight_update_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wu_state_t;

    // Width of a chunk index; never below one bit so a single-chunk build still has a port.
    function automatic int chunk_addr_w(input int features, input int lanes);
        return (features / lanes > 1) ? $clog2(features / lanes) : 1;
    endfunction

    function automatic logic signed [63:0] fx_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] fx_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/weight_update_if.sv
// Error handshake, buffer read port and weight write port of the weight updater.
interface weight_update_if
    import weight_update_pkg::*;
#(
    parameter int bitwidth      = 32,
    parameter int inputBitwidth = 16,
    parameter int LANES         = 4,
    parameter int FEATURES      = 64
);
    localparam int AW = chunk_addr_w(FEATURES, LANES);
    localparam int DW = LANES * inputBitwidth;

    logic signed [bitwidth-1:0] err_in;
    logic                       err_valid;
    logic                       err_ready;
    logic                       rd_en;
    logic [AW-1:0]              rd_addr;
    logic [DW-1:0]              w_rd_data;
    logic [DW-1:0]              x_rd_data;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [DW-1:0]              wr_data;
    logic                       busy;
    logic                       done;

    // Error stage and weight/feature buffers.
    modport master (
        output err_in, err_valid, w_rd_data, x_rd_data,
        input  err_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );

    // The weight updater itself.
    modport slave (
        input  err_in, err_valid, w_rd_data, x_rd_data,
        output err_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );

endinterface

// File: rtl/weight_update_wu_lane.sv
// One lane of w - ((err * x) >>> fracBitwidth), saturating under WEIGHT_SAT_EN, wrapping otherwise.
// Latency: combinational. Backpressure: none, the caller registers the result.
module wu_lane
    import weight_update_pkg::*;
#(
    parameter int bitwidth      = 32,
    parameter int inputBitwidth = 16,
    parameter int fracBitwidth  = 7
) (
    input  logic signed [bitwidth-1:0]      err,
    input  logic signed [inputBitwidth-1:0] x,
    input  logic signed [inputBitwidth-1:0] w,
    output logic        [inputBitwidth-1:0] w_new
);
    localparam int PW = bitwidth + inputBitwidth;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] delta;
    logic        [PW:0]   diff;

    assign prod  = PW'(err) * PW'(x);
    assign delta = prod >>> fracBitwidth;
    // One guard bit above the product so the subtraction itself never overflows.
    assign diff  = {{(PW + 1 - inputBitwidth){w[inputBitwidth-1]}}, w} - {delta[PW-1], delta};

`ifdef WEIGHT_SAT_EN
    logic fits;

    assign fits = (&diff[PW:inputBitwidth-1]) | ~(|diff[PW:inputBitwidth-1]);

    always_comb begin
        w_new = diff[inputBitwidth-1:0];
        if (!fits) begin
            w_new = diff[PW] ? inputBitwidth'(fx_min(inputBitwidth))
                             : inputBitwidth'(fx_max(inputBitwidth));
        end
    end
`else
    logic unused_diff_hi;

    assign unused_diff_hi = ^diff[PW:inputBitwidth];
    assign w_new          = diff[inputBitwidth-1:0];
`endif

endmodule

// File: rtl/weight_update.sv
// Sweeps the weight buffer applying one scaled error per sample; WEIGHT_SAT_EN selects saturating lanes.
// Latency: chunk k read at handshake+1+k, written at +3+k, done at +N+3, ready again at +N+4.
// Backpressure: err_ready only in IDLE; the buffer ports have no stall and assume 1-cycle reads.
module weight_update
    import weight_update_pkg::*;
#(
    parameter int bitwidth      = 32,
    parameter int inputBitwidth = 16,
    parameter int fracBitwidth  = 7,
    parameter int LANES         = 4,
    parameter int FEATURES      = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    weight_update_if.slave bus
);
    localparam int            N    = FEATURES / LANES;
    localparam int            AW   = chunk_addr_w(FEATURES, LANES);
    localparam int            DW   = LANES * inputBitwidth;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    wu_state_t                  state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic signed [bitwidth-1:0] err_q;

    logic                       err_ready, rd_en, busy, done;
    logic [AW-1:0]              rd_addr;

    logic                       rd_vld_q;
    logic [AW-1:0]              rd_addr_q;
    logic                       wr_en_q;
    logic [AW-1:0]              wr_addr_q;
    logic [DW-1:0]              wr_data_q;
    logic [DW-1:0]              w_new;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.err_valid) begin
                err_q <= bus.err_in;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_ready = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = cnt_q;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                err_ready = 1'b1;
                if (bus.err_valid) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rd_en = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            // The last chunk's write is visible two cycles after its read was issued.
            DRAIN: begin
                if (wr_en_q && wr_addr_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        wu_lane #(
            .bitwidth     (bitwidth),
            .inputBitwidth(inputBitwidth),
            .fracBitwidth (fracBitwidth)
        ) u_lane (
            .err  (err_q),
            .x    (bus.x_rd_data[i*inputBitwidth +: inputBitwidth]),
            .w    (bus.w_rd_data[i*inputBitwidth +: inputBitwidth]),
            .w_new(w_new[i*inputBitwidth +: inputBitwidth])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_addr_q <= rd_addr;
            wr_en_q   <= rd_vld_q;
            wr_addr_q <= rd_addr_q;
            if (rd_vld_q) begin
                wr_data_q <= w_new;
            end
        end
    end

    assign bus.err_ready = err_ready;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_weight_update.sv
// Directed bench for weight_update with FEATURES=8, LANES=4 and a 1-cycle weight/feature memory model.
module tb_weight_update;
    localparam int BW  = 32;
    localparam int IBW = 16;
    localparam int FB  = 7;
    localparam int L   = 4;
    localparam int F   = 8;
    localparam int N   = F / L;
    localparam int AW  = 1;
    localparam int DW  = L * IBW;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    weight_update_if #(.bitwidth(BW), .inputBitwidth(IBW), .LANES(L), .FEATURES(F)) bus ();

    weight_update #(
        .bitwidth(BW), .inputBitwidth(IBW), .fracBitwidth(FB), .LANES(L), .FEATURES(F)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] wmem   [0:N-1];
    logic [DW-1:0] xmem   [0:N-1];
    logic [DW-1:0] w_init [0:N-1];
    logic [DW-1:0] x_init [0:N-1];
    logic          load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) begin
                wmem[i] <= w_init[i];
                xmem[i] <= x_init[i];
            end
        end else if (bus.wr_en) begin
            wmem[bus.wr_addr] <= bus.wr_data;
        end
        if (bus.rd_en) begin
            bus.w_rd_data <= wmem[bus.rd_addr];
            bus.x_rd_data <= xmem[bus.rd_addr];
        end
    end

    logic          ob_rd_en   [0:15];
    logic [AW-1:0] ob_rd_addr [0:15];
    logic          ob_wr_en   [0:15];
    logic [AW-1:0] ob_wr_addr [0:15];
    logic [DW-1:0] ob_wr_dat  [0:15];
    logic          ob_done    [0:15];
    logic          ob_rdy     [0:15];
    logic          ob_busy    [0:15];

    task automatic load_pulse();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic load_uniform(input logic [IBW-1:0] w, input logic [IBW-1:0] x);
        for (int i = 0; i < N; i++) begin
            w_init[i] = {L{w}};
            x_init[i] = {L{x}};
        end
        load_pulse();
    endtask

    // Cycle 0 is the handshake cycle; observations r=1..ncyc are taken mid-cycle after each edge.
    task automatic sweep(input logic signed [BW-1:0] err, input int ncyc, input bit hold,
                         input logic signed [BW-1:0] err_after, input int rst_at);
        @(negedge clk);
        bus.err_in    = err;
        bus.err_valid = 1'b1;
        for (int r = 1; r <= ncyc; r++) begin
            @(negedge clk);
            if (hold) bus.err_in = err_after;
            else      bus.err_valid = 1'b0;
            ob_rd_en[r]   = bus.rd_en;
            ob_rd_addr[r] = bus.rd_addr;
            ob_wr_en[r]   = bus.wr_en;
            ob_wr_addr[r] = bus.wr_addr;
            ob_wr_dat[r]  = bus.wr_data;
            ob_done[r]    = bus.done;
            ob_rdy[r]     = bus.err_ready;
            ob_busy[r]    = bus.busy;
            if (r == rst_at)     rst_n = 1'b0;
            if (r == rst_at + 1) rst_n = 1'b1;
        end
        bus.err_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(bus.err_ready && !bus.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(bus.err_ready && !bus.busy)) begin
            bad++;
            $display("FAIL %s idle timeout: err_ready=%b busy=%b required 1/0", tag, bus.err_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.err_ready, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr} !== 5'b10000) begin
            bad++;
            $display("FAIL reset ctrl: rdy/rd_en/rd_addr/wr_en/wr_addr=%b required 10000",
                     {bus.err_ready, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr});
        end
        total++;
        if (bus.wr_data !== '0) begin
            bad++;
            $display("FAIL reset wr_data: got %h required 0", bus.wr_data);
        end
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++;
            $display("FAIL reset busy/done: got %b required 00", {bus.busy, bus.done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp;
        exp = {L{16'd744}};
        load_uniform(16'd1000, 16'd256);
        sweep(32'sd128, 8, 1'b0, 32'sd0, -1);
        total++;
        if ({ob_rd_en[1], ob_rd_addr[1], ob_rd_en[2], ob_rd_addr[2], ob_rd_en[3]} !== 5'b10110) begin
            bad++;
            $display("FAIL basic reads: en/addr c1,c2,en c3=%b required 10110",
                     {ob_rd_en[1], ob_rd_addr[1], ob_rd_en[2], ob_rd_addr[2], ob_rd_en[3]});
        end
        total++;
        if ({ob_wr_en[2], ob_wr_en[3], ob_wr_addr[3], ob_wr_en[4], ob_wr_addr[4], ob_wr_en[5]} !== 6'b010110) begin
            bad++;
            $display("FAIL basic write timing: got %b required 010110",
                     {ob_wr_en[2], ob_wr_en[3], ob_wr_addr[3], ob_wr_en[4], ob_wr_addr[4], ob_wr_en[5]});
        end
        total++;
        if (ob_wr_dat[3] !== exp) begin
            bad++;
            $display("FAIL basic chunk0 data: got %h required %h", ob_wr_dat[3], exp);
        end
        total++;
        if (ob_wr_dat[4] !== exp) begin
            bad++;
            $display("FAIL basic chunk1 data: got %h required %h", ob_wr_dat[4], exp);
        end
        total++;
        if ({ob_done[4], ob_done[5], ob_done[6]} !== 3'b010) begin
            bad++;
            $display("FAIL basic done c4..c6: got %b required 010", {ob_done[4], ob_done[5], ob_done[6]});
        end
        total++;
        if ({ob_rdy[5], ob_rdy[6], ob_busy[1], ob_busy[5], ob_busy[6]} !== 5'b01110) begin
            bad++;
            $display("FAIL basic ready/busy: got %b required 01110",
                     {ob_rdy[5], ob_rdy[6], ob_busy[1], ob_busy[5], ob_busy[6]});
        end
        total++;
        if (wmem[0] !== exp || wmem[1] !== exp) begin
            bad++;
            $display("FAIL basic memory: got %h %h required %h", wmem[0], wmem[1], exp);
        end
    endtask

    task automatic test_negative();
        logic [DW-1:0] exp;
        exp = {L{16'd64}};
        load_uniform(16'd0, 16'd128);
        sweep(-32'sd64, 7, 1'b0, 32'sd0, -1);
        total++;
        if (ob_wr_dat[3] !== exp || ob_wr_dat[4] !== exp) begin
            bad++;
            $display("FAIL negative data: got %h %h required %h", ob_wr_dat[3], ob_wr_dat[4], exp);
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] exp;
`ifdef WEIGHT_SAT_EN
        exp = {L{16'h8000}};
`else
        exp = {L{16'h7C5C}};
`endif
        load_uniform(16'h8044, 16'd1000);
        sweep(32'sd128, 7, 1'b0, 32'sd0, -1);
        total++;
        if (ob_wr_dat[3] !== exp || ob_wr_dat[4] !== exp) begin
            bad++;
            $display("FAIL saturation data: got %h %h required %h", ob_wr_dat[3], ob_wr_dat[4], exp);
        end
    endtask

    task automatic test_busy_protect();
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        int dn;
        int wn;
        exp1 = {L{16'd744}};
        exp2 = {L{16'd232}};
        load_uniform(16'd1000, 16'd256);
        sweep(32'sd128, 9, 1'b1, 32'sd256, -1);
        dn = 0;
        wn = 0;
        for (int r = 1; r <= 9; r++) if (ob_done[r]) dn++;
        for (int r = 5; r <= 8; r++) if (ob_wr_en[r]) wn++;
        total++;
        if (dn != 1 || !ob_done[5]) begin
            bad++;
            $display("FAIL busy done pulses: got count=%0d c5=%b required 1 at c5", dn, ob_done[5]);
        end
        total++;
        if ({ob_rdy[5], ob_rdy[6], ob_rdy[7], ob_rd_en[7]} !== 4'b0101) begin
            bad++;
            $display("FAIL busy second accept: rdy c5..c7,rd_en c7=%b required 0101",
                     {ob_rdy[5], ob_rdy[6], ob_rdy[7], ob_rd_en[7]});
        end
        total++;
        if (ob_wr_dat[3] !== exp1 || ob_wr_dat[4] !== exp1) begin
            bad++;
            $display("FAIL busy err_q hold: got %h %h required %h", ob_wr_dat[3], ob_wr_dat[4], exp1);
        end
        total++;
        if (wn != 0 || !ob_wr_en[9] || ob_wr_dat[9] !== exp2) begin
            bad++;
            $display("FAIL busy second sweep: gap writes=%0d c9 en=%b data=%h required 0/1/%h",
                     wn, ob_wr_en[9], ob_wr_dat[9], exp2);
        end
        wait_idle("busy");
        total++;
        if (wmem[0] !== exp2 || wmem[1] !== exp2) begin
            bad++;
            $display("FAIL busy memory: got %h %h required %h", wmem[0], wmem[1], exp2);
        end
    endtask

    task automatic test_reset_mid();
        int wn;
        load_uniform(16'd1000, 16'd256);
        sweep(32'sd128, 10, 1'b0, 32'sd0, 3);
        total++;
        if ({ob_wr_en[3], ob_wr_en[4], ob_busy[4], ob_rdy[4], ob_done[4]} !== 5'b10010) begin
            bad++;
            $display("FAIL midreset next cycle: wr3/wr4/busy/rdy/done=%b required 10010",
                     {ob_wr_en[3], ob_wr_en[4], ob_busy[4], ob_rdy[4], ob_done[4]});
        end
        wn = 0;
        for (int r = 4; r <= 10; r++) if (ob_wr_en[r] || ob_done[r] || ob_rd_en[r]) wn++;
        total++;
        if (wn != 0 || wmem[1] !== {L{16'd1000}}) begin
            bad++;
            $display("FAIL midreset quiet: activity=%0d chunk1=%h required 0/%h", wn, wmem[1], {L{16'd1000}});
        end
        load_uniform(16'd1000, 16'd256);
        sweep(32'sd128, 7, 1'b0, 32'sd0, -1);
        total++;
        if (!ob_done[5] || ob_wr_dat[4] !== {L{16'd744}} || !ob_rdy[6]) begin
            bad++;
            $display("FAIL midreset fresh sweep: done5=%b data=%h rdy6=%b required 1/%h/1",
                     ob_done[5], ob_wr_dat[4], ob_rdy[6], {L{16'd744}});
        end
    endtask

    task automatic test_zero_error();
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        w_init[0] = w0;
        w_init[1] = w1;
        x_init[0] = {$urandom, $urandom};
        x_init[1] = {$urandom, $urandom};
        load_pulse();
        sweep(32'sd0, 7, 1'b0, 32'sd0, -1);
        total++;
        if (ob_wr_dat[3] !== w0 || ob_wr_dat[4] !== w1) begin
            bad++;
            $display("FAIL zero error: got %h %h required %h %h", ob_wr_dat[3], ob_wr_dat[4], w0, w1);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        load = 1'b0;
        rst_n = 1'b0;
        bus.err_valid = 1'b0;
        bus.err_in = '0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_busy_protect();
        test_reset_mid();
        test_zero_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_update.md
# weight_update

Backward-path weight updater for Axiline training. It accepts one scalar error term from the combinational loss/gradient stage; that term is already scaled by the learning rate `mu`. It then sweeps the weight memory in `LANES`-wide chunks, computing `w <- w - ((err * x) >>> fracBitwidth)` per lane. It is the consumer of the error stage's output and writes the weights that the forward dot-product path reads on the next sample.

## Interface
- `bitwidth`, 32: width of the error term `err_in`.
- `inputBitwidth`, 16: width of one weight and one feature element (signed fixed point).
- `fracBitwidth`, 7: fractional bits shared by weights, features and error.
- `LANES`, 4: elements processed per cycle.
- `FEATURES`, 64: vector length. Must be a multiple of `LANES`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `err_in`  in  `bitwidth`  signed scaled error. Sampled on handshake.
- `err_valid`  in  1  error term available.
- `err_ready`  out  1  block idle and able to accept an error.
- `rd_en`  out  1  read strobe to the weight and feature buffers.
- `rd_addr`  out  `$clog2(FEATURES/LANES)`  chunk index to read.
- `w_rd_data`  in  `LANES*inputBitwidth`  weights, valid 1 cycle after `rd_en`.
- `x_rd_data`  in  `LANES*inputBitwidth`  features, valid 1 cycle after `rd_en`.
- `wr_en`  out  1  weight write strobe.
- `wr_addr`  out  `$clog2(FEATURES/LANES)`  chunk index written.
- `wr_data`  out  `LANES*inputBitwidth`  updated weights. Lane i occupies bits `[i*inputBitwidth +: inputBitwidth]`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when the sweep completes.

## Operation
- FSM states:
  - IDLE: `err_ready`=1. On `err_valid`, latch `err_in` into `err_q`, clear the chunk counter and go to RUN.
  - RUN: assert `rd_en` with `rd_addr`=counter, then increment. After issuing chunk N-1 (N=`FEATURES/LANES`), go to DRAIN.
  - DRAIN: wait for the in-flight reads and writes to retire, then go to DONE.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- Datapath is 2 stages:
  - Stage 1 (read return): per lane, `prod = $signed(err_q) * $signed(x)` at full width `bitwidth+inputBitwidth`.
  - Then `delta = prod >>> fracBitwidth`, an arithmetic shift.
  - Then `w_new = w - delta`, computed at full width and reduced to `inputBitwidth` per Configuration.
  - Stage 2 registers `wr_data`, `wr_addr` and `wr_en`.
- The write address is the read address delayed 2 cycles. Read chunk k and write chunk k-2 never coincide, so there is no hazard.
- `err_in`=0 still performs a full sweep; weights are written back unchanged.
- `err_valid` asserted while busy is ignored. `err_ready`=0 outside IDLE.
- `busy`=1 in RUN, DRAIN and DONE.

## Timing
- Reset values:
  - `err_ready`=1.
  - `rd_en`=0, `rd_addr`=0.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy`=0, `done`=0.
  - `err_q`=0, FSM in IDLE.
- Handshake at cycle 0, then:
  - First `rd_en` at cycle 1.
  - Chunk k read at cycle 1+k, write at cycle 3+k.
  - Last write at cycle N+2.
  - `done` at cycle N+3.
  - `err_ready` high again at cycle N+4.
- Throughput is one chunk per cycle with no bubbles. Back-to-back errors are separated by N+4 cycles.
- A reset asserted mid-sweep takes effect at the next edge: all outputs go to reset values and the pipeline valid bits clear. No write issues after reset. Partially updated memory is not rolled back.
- Memory read latency is exactly 1 cycle. Any other latency is unsupported.

## Configuration
- `WEIGHT_SAT_EN` defined: `w_new` saturates to `[-2^(inputBitwidth-1), 2^(inputBitwidth-1)-1]`.
- `WEIGHT_SAT_EN` undefined: `w_new` truncates to the low `inputBitwidth` bits (two's-complement wrap).
- The macro does not affect timing.

## Structure
- Shared package holds:
  - The FSM state encoding (IDLE, RUN, DRAIN, DONE).
  - The chunk-address width function.
  - The fixed-point min/max constants.
- One sub-module, `wu_lane`, holds a single lane's multiply, shift, subtract and saturate/wrap logic. It is instantiated `LANES` times with a generate loop.

## Test plan
Test parameters: FEATURES=8, LANES=4, fracBitwidth=7. Values are shown as raw signed integers.
- Basic update: reset, then handshake `err_in`=128 with all x=256 and all w=1000.
  - Writes to chunks 0 and 1 with every lane = 744.
  - `done` at cycle 5, `err_ready` at cycle 6.
- Negative error: `err_in`=-64, x=128, w=0 → every lane = 64.
- Saturation boundary: `err_in`=128, x=1000, w=-32700.
  - With `WEIGHT_SAT_EN` → -32768.
  - Without it → 31836.
- Busy protection: assert `err_valid` continuously through a sweep.
  - Exactly one sweep.
  - Second error accepted only at cycle 6.
  - `err_q` unchanged mid-sweep.
- Reset mid-sweep: deassert `rst_n` at cycle 3.
  - Next cycle: `wr_en`=0, `busy`=0, `err_ready`=1.
  - No further writes.
  - A fresh sweep afterward completes normally.
- Zero error: `err_in`=0 with random w → written data equals read data on every lane.
